// File: rtl/pool1_pkg.sv
// Shared constants, row-phase state type and signed max helper for the pool1 layer.
package pool1_pkg;
    localparam int CH     = 32;
    localparam int DATA_W = 32;

    typedef enum logic {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } row_state_t;

    // Ties return b; either operand is an acceptable result for equal values.
    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/pool1_line_buf.sv
// Half-width line buffer holding the horizontal maxima of the even row for every channel.
import pool1_pkg::*;

module pool1_line_buf #(
    parameter int DEPTH = 12,
    parameter int AW    = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic signed [DATA_W-1:0] wdata [0:CH-1],
    input  logic [AW-1:0]            raddr,
    output logic signed [DATA_W-1:0] rdata [0:CH-1]
);
    logic signed [DATA_W-1:0] mem [0:DEPTH-1][0:CH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int c = 0; c < CH; c++) begin
                mem[waddr][c] <= wdata[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            rdata[c] = mem[raddr][c];
        end
    end
endmodule

// File: rtl/pool1_layer.sv
// 2x2 stride-2 signed max pooling over a raster-order conv1 feature map.
// Defining POOL1_RELU_EN clamps negative pooled results to zero.
import pool1_pkg::*;

module pool1_layer #(
    parameter int IMG_W = 24,
    parameter int IMG_H = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic signed [DATA_W-1:0] conv1_in [0:CH-1],
    output logic                     valid_out,
    output logic signed [DATA_W-1:0] pool1_out [0:CH-1],
    output logic                     frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int AW = CW - 1;
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]            col;
    logic [RW-1:0]            row;
    row_state_t               state;
    logic signed [DATA_W-1:0] hold      [0:CH-1];
    logic signed [DATA_W-1:0] hmax      [0:CH-1];
    logic signed [DATA_W-1:0] lb_rdata  [0:CH-1];
    logic signed [DATA_W-1:0] pool_next [0:CH-1];
    logic                     accept;
    logic                     lb_we;

    assign accept = valid_in && !rst;
    assign lb_we  = accept && col[0] && (state == EVEN_ROW);

    // The same entry is written on even rows and read back on odd rows at the same column pair.
    pool1_line_buf #(
        .DEPTH (IMG_W / 2),
        .AW    (AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (col[CW-1:1]),
        .wdata (hmax),
        .raddr (col[CW-1:1]),
        .rdata (lb_rdata)
    );

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            hmax[c]      = smax(hold[c], conv1_in[c]);
            pool_next[c] = smax(lb_rdata[c], hmax[c]);
`ifdef POOL1_RELU_EN
            if (pool_next[c][DATA_W-1]) begin
                pool_next[c] = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            state      <= EVEN_ROW;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                hold[c]      <= '0;
                pool1_out[c] <= '0;
            end
        end else begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            if (accept) begin
                if (!col[0]) begin
                    for (int c = 0; c < CH; c++) begin
                        hold[c] <= conv1_in[c];
                    end
                end else if (state == ODD_ROW) begin
                    for (int c = 0; c < CH; c++) begin
                        pool1_out[c] <= pool_next[c];
                    end
                    valid_out  <= 1'b1;
                    frame_done <= (row == ROW_LAST) && (col == COL_LAST);
                end
                if (col == COL_LAST) begin
                    col   <= '0;
                    state <= (state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
                    row   <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pool1_layer.sv
// Self-checking bench for pool1_layer: scenario table plus reset-mid-frame sequence, scoreboard-checked.
module tb_pool1_layer;
    localparam int CH    = 32;
    localparam int IMG_W = 24;
    localparam int IMG_H = 24;

    logic clk = 1'b0;
    logic rst;
    logic valid_in;
    logic signed [31:0] conv1_in  [0:CH-1];
    logic signed [31:0] pool1_out [0:CH-1];
    logic valid_out;
    logic frame_done;

    pool1_layer #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .conv1_in   (conv1_in),
        .valid_out  (valid_out),
        .pool1_out  (pool1_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0][31:0] val;
        logic                done;
    } exp_t;

    typedef struct {
        int                 pat0;
        int                 pat1;
        int                 frames;
        bit                 gap;
        bit                 check_ends;
        int                 exp_pulses;
        int                 exp_dones;
        logic signed [31:0] exp_first;
        logic signed [31:0] exp_last;
    } vec_t;

    exp_t               sb[$];
    logic [CH-1:0][31:0] last_exp;
    int                 nvec = 0;
    int                 nerr = 0;
    int                 pulses, dones;
    bit                 seen_first;
    logic signed [31:0] first_val, last_val;

    // Pixel generators: 0 zeros, 1 raster ramp, 2 negative quadrants with channel offset, 3 hashed full-range.
    function automatic logic signed [31:0] pix(int pat, int r, int c, int ch);
        logic [31:0] h;
        logic signed [31:0] q;
        case (pat)
            1: return 32'(r * IMG_W + c);
            2: begin
                case ({r[0], c[0]})
                    2'b00:   q = -5;
                    2'b01:   q = -3;
                    2'b10:   q = -9;
                    default: q = -7;
                endcase
                return q + 32'(ch);
            end
            3: begin
                h = 32'(r * 7919 + c * 104729 + ch * 1299709 + 17);
                h = h * 32'h9E3779B1;
                h = h ^ (h >> 15);
                return $signed(h);
            end
            default: return 32'sd0;
        endcase
    endfunction

    function automatic logic signed [31:0] smax_ref(logic signed [31:0] a, logic signed [31:0] b);
        return (a >= b) ? a : b;
    endfunction

    task automatic check(string name, bit ok, longint act, longint req);
        nvec++;
        if (!ok) begin
            nerr++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        int   bad;
        if (valid_out) begin
            check("valid_out expected", sb.size() != 0, 1, 0);
            if (sb.size() != 0) begin
                e   = sb.pop_front();
                bad = -1;
                for (int c = CH - 1; c >= 0; c--)
                    if (pool1_out[c] !== $signed(e.val[c])) bad = c;
                if (bad < 0) check("pool1_out", 1'b1, 0, 0);
                else check($sformatf("pool1_out[%0d]", bad), 1'b0, pool1_out[bad], $signed(e.val[bad]));
                check("frame_done", frame_done === e.done, frame_done, e.done);
                last_exp = e.val;
                pulses++;
                if (frame_done) dones++;
                if (!seen_first) first_val = pool1_out[0];
                seen_first = 1'b1;
                last_val   = pool1_out[0];
            end
        end else begin
            bad = -1;
            for (int c = CH - 1; c >= 0; c--)
                if (pool1_out[c] !== $signed(last_exp[c])) bad = c;
            if (bad < 0) check("hold", frame_done === 1'b0, frame_done, 0);
            else check($sformatf("hold[%0d]", bad), 1'b0, pool1_out[bad], $signed(last_exp[bad]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(int pat, int r, int c, bit gap);
        exp_t               e;
        logic signed [31:0] m;
        for (int ch = 0; ch < CH; ch++) conv1_in[ch] = pix(pat, r, c, ch);
        valid_in = 1'b1;
        if (r[0] && c[0]) begin
            for (int ch = 0; ch < CH; ch++) begin
                m = smax_ref(smax_ref(pix(pat, r - 1, c - 1, ch), pix(pat, r - 1, c, ch)),
                             smax_ref(pix(pat, r, c - 1, ch), pix(pat, r, c, ch)));
`ifdef POOL1_RELU_EN
                if (m < 0) m = 0;
`endif
                e.val[ch] = m;
            end
            e.done = (r == IMG_H - 1) && (c == IMG_W - 1);
            sb.push_back(e);
        end
        tick();
        valid_in = 1'b0;
        for (int ch = 0; ch < CH; ch++) conv1_in[ch] = 32'sh5A5A5A5A ^ 32'(ch);
        if (gap) tick();
    endtask

    task automatic resetDut();
        rst      = 1'b1;
        valid_in = 1'b1;
        for (int ch = 0; ch < CH; ch++) conv1_in[ch] = -32'sd1000 - 32'(ch);
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        valid_in = 1'b0;
        sb.delete();
        last_exp = '0;
        check("reset valid_out", valid_out === 1'b0, valid_out, 0);
        check("reset frame_done", frame_done === 1'b0, frame_done, 0);
        check("reset pool1_out[0]", pool1_out[0] === 32'sd0, pool1_out[0], 0);
        check("reset pool1_out[31]", pool1_out[CH-1] === 32'sd0, pool1_out[CH-1], 0);
    endtask

    task automatic clearStats();
        pulses = 0; dones = 0; seen_first = 1'b0; first_val = 0; last_val = 0;
    endtask

    task automatic runFrame(int pat, bit gap);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                applyStimulus(pat, r, c, gap);
    endtask

    task automatic endChecks(string tag, int exp_p, int exp_d);
        repeat (3) tick();
        check({tag, " pulses"}, pulses == exp_p, pulses, exp_p);
        check({tag, " frame_done count"}, dones == exp_d, dones, exp_d);
        check({tag, " scoreboard empty"}, sb.size() == 0, sb.size(), 0);
    endtask

    vec_t vecs[6];
    logic signed [31:0] quad_out;

    initial begin
`ifdef POOL1_RELU_EN
        quad_out = 0;
`else
        quad_out = -3;
`endif
        vecs[0] = '{0, 0, 1, 1'b0, 1'b1, 144, 1, 0, 0};
        vecs[1] = '{1, 1, 1, 1'b0, 1'b1, 144, 1, 25, 575};
        vecs[2] = '{2, 2, 1, 1'b0, 1'b1, 144, 1, quad_out, quad_out};
        vecs[3] = '{1, 1, 1, 1'b1, 1'b1, 144, 1, 25, 575};
        vecs[4] = '{3, 3, 1, 1'b1, 1'b0, 144, 1, 0, 0};
        vecs[5] = '{1, 2, 2, 1'b0, 1'b1, 288, 2, 25, quad_out};

        valid_in = 1'b0;
        rst      = 1'b0;
        for (int ch = 0; ch < CH; ch++) conv1_in[ch] = '0;
        resetDut();

        for (int i = 0; i < 6; i++) begin
            clearStats();
            for (int f = 0; f < vecs[i].frames; f++)
                runFrame((f == 0) ? vecs[i].pat0 : vecs[i].pat1, vecs[i].gap);
            endChecks($sformatf("vec%0d", i), vecs[i].exp_pulses, vecs[i].exp_dones);
            if (vecs[i].check_ends) begin
                check($sformatf("vec%0d first", i), first_val == vecs[i].exp_first, first_val, vecs[i].exp_first);
                check($sformatf("vec%0d last", i), last_val == vecs[i].exp_last, last_val, vecs[i].exp_last);
            end
        end

        // Abandon a ramp frame after 100 pixels, reset, then a full hashed frame must pool cleanly.
        for (int p = 0; p < 100; p++) applyStimulus(1, p / IMG_W, p % IMG_W, 1'b0);
        resetDut();
        clearStats();
        repeat (2) tick();
        runFrame(3, 1'b0);
        endChecks("post-reset", 144, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/pool1_layer.md
POOL1_LAYER -- requirements
Module: pool1_layer

Interface
REQ-001 The block SHALL have parameter IMG_W, default 24, meaning conv1 output map width in pixels; the value SHALL be even.
REQ-002 The block SHALL have parameter IMG_H, default 24, meaning conv1 output map height in rows; the value SHALL be even.
REQ-003 The block SHALL have port clk, input, width 1, meaning the single clock.
REQ-004 The block SHALL have port rst, input, width 1, meaning the synchronous, active-high reset.
REQ-005 The block SHALL have port valid_in, input, width 1, meaning conv1_in carries one valid pixel, all channels.
REQ-006 The block SHALL have port conv1_in[0:31], input, 32 each, meaning conv1 channel results for one pixel, signed two's complement.
REQ-007 The block SHALL have port valid_out, output, width 1, meaning pool1_out carries one pooled pixel.
REQ-008 The block SHALL have port pool1_out[0:31], output, 32 each, meaning the 2x2 max per channel, signed.
REQ-009 The block SHALL have port frame_done, output, width 1, meaning a one-cycle pulse on the final pooled pixel of a frame.

Function
REQ-010 The block SHALL consume pixels in raster order, one per cycle with valid_in=1; cycles with valid_in=0 SHALL leave all state unchanged (gaps anywhere allowed).
REQ-011 The column counter col (0..IMG_W-1) and the row counter row (0..IMG_H-1) SHALL advance only on accepted pixels; col SHALL wrap to 0 and row SHALL advance; row SHALL wrap to 0 after IMG_H-1.
REQ-012 The state machine SHALL have the states EVEN_ROW and ODD_ROW: EVEN_ROW->ODD_ROW on the last pixel of an even row, ODD_ROW->EVEN_ROW on the last pixel of an odd row.
REQ-013 On even col, the block SHALL hold the pixel in a 32-channel hold register.
REQ-014 On odd col, the block SHALL compute hmax[c] = signed max(hold[c], conv1_in[c]).
REQ-015 In EVEN_ROW, hmax SHALL be written to line buffer entry col/2 (IMG_W/2 entries x 32 channels x 32 bits).
REQ-016 In ODD_ROW, the block SHALL compute pool1_out[c] = signed max(linebuf[col/2][c], hmax[c]) and register it, with valid_out=1 exactly one cycle after the accepting edge of the odd-row/odd-col pixel.
REQ-017 valid_out SHALL be 1 for exactly one cycle per pooled pixel; there SHALL be (IMG_W/2)*(IMG_H/2) pulses per frame.
REQ-018 frame_done SHALL assert in the same cycle as valid_out for row=IMG_H-1, col=IMG_W-1.
REQ-019 pool1_out SHALL hold its last value while valid_out=0.
REQ-020 Compares SHALL be signed 32-bit with no truncation; for equal values either operand is acceptable.
REQ-021 A back-to-back frame (pixel 0 arriving the cycle after the last pixel) SHALL be accepted without a bubble.

Reset
REQ-022 rst=1 at a clock edge SHALL clear col, row, state (to EVEN_ROW), hold, valid_out, frame_done and pool1_out to 0; line buffer contents need no reset.
REQ-023 rst asserted mid-frame SHALL discard the partial frame; the first pixel after rst deasserts SHALL be treated as row 0, col 0.
REQ-024 valid_in SHALL be ignored during any cycle in which rst=1.

Configuration
REQ-025 With POOL1_RELU_EN defined, each registered pool1_out[c] SHALL be clamped to 0 when negative; without it, the signed max SHALL pass unmodified.

Structure
REQ-026 Package pool1_pkg SHALL hold CH=32, DATA_W=32 and the state enum type (EVEN_ROW, ODD_ROW).
REQ-027 The line buffer SHALL be the sub-module pool1_line_buf (single write port, single read port, combinational read, IMG_W/2 deep).

Verification
REQ-028 All-zero frame, 576 pixels continuous -> 144 valid_out pulses, all outputs 0, frame_done on pulse 144.
REQ-029 Pixel value = row*24+col on all channels -> first output 25, last output 575, outputs spaced 2 cycles apart on odd rows.
REQ-030 Channel c quadrant values {-5,-3,-9,-7} with c-dependent offset -> output -3+offset; with POOL1_RELU_EN, output 0.
REQ-031 valid_in toggling 1/0 each cycle over a full frame -> results identical to the continuous run, 144 pulses.
REQ-032 rst pulsed after 100 pixels, then a full frame -> no stale output, exactly 144 correct pulses, single frame_done.
REQ-033 Two back-to-back frames -> 288 pulses, frame_done twice, second frame unaffected by first-frame line buffer contents.
